// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter unit.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  // Arbitration modes, matching the ROUND_ROBIN parameter encoding.
  localparam logic ARB_FIXED       = 1'b0;
  localparam logic ARB_ROUND_ROBIN = 1'b1;

  localparam int DEFAULT_CHANNELS       = 2;
  localparam int DEFAULT_ADDRESS_WIDTH  = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Bits needed to index 'count' items, never less than one.
  function automatic int index_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_picker.sv
// Combinational winner selection: fixed priority (lowest index) or
// round-robin starting just above the last granted channel.
module bus_arbiter_picker
  import bus_pkg::*;
#(
  parameter  int CHANNELS    = DEFAULT_CHANNELS,
  localparam int GRANT_WIDTH = index_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0]    req_valid,
  input  logic [GRANT_WIDTH-1:0] last_grant,
  input  logic                   mode,
  output logic [GRANT_WIDTH-1:0] winner,
  output logic                   any_valid
);

  logic [GRANT_WIDTH-1:0] winner_low;
  logic [GRANT_WIDTH-1:0] winner_high;
  logic                   found_high;

  // Lowest requester overall, and lowest requester above last_grant; the
  // latter wins in round-robin mode, otherwise the search wraps to the former.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    winner_low  = '0;
    winner_high = '0;
    found_high  = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        winner_low = GRANT_WIDTH'(i);
        if (i > int'(last_grant)) begin
          winner_high = GRANT_WIDTH'(i);
          found_high  = 1'b1;
        end
      end
    end
    any_valid = |req_valid;
    winner    = (mode == ARB_ROUND_ROBIN && found_high) ? winner_high : winner_low;
  end

endmodule

// File: rtl/bus_arbiter_unit.sv
// Multi-channel bus front end: arbitrates requesters onto one external bus,
// holds the handshake, returns a one-cycle ready pulse with registered read
// data, and aborts stuck transfers through a watchdog.
module bus_arbiter_unit
  import bus_pkg::*;
#(
  parameter  int CHANNELS       = DEFAULT_CHANNELS,
  parameter  int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter  int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter  bit ROUND_ROBIN    = 1'b1,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int GRANT_WIDTH    = index_width(CHANNELS)
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [CHANNELS-1:0]               i_req_vaild,
  output logic [CHANNELS-1:0]               o_req_ready,
  output logic                              o_req_error,
  input  logic [CHANNELS-1:0]               i_req_write_enable,
  input  logic [CHANNELS*ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [CHANNELS*DATA_WIDTH-1:0]    i_req_data_write,
  output logic [DATA_WIDTH-1:0]             o_req_data_read,
  output logic                              o_bus_vaild,
  output logic                              o_bus_write_enable,
  output logic [ADDRESS_WIDTH-1:0]          o_bus_address,
  output logic [DATA_WIDTH-1:0]             o_bus_data_write,
  input  logic                              i_bus_ready,
  input  logic                              i_bus_busy,
  input  logic [DATA_WIDTH-1:0]             i_bus_data_read,
  output logic [GRANT_WIDTH-1:0]            o_grant_id
);

  localparam int WD_WIDTH = index_width(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 : WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_WIDTH-1:0] WD_ONE = WD_WIDTH'(1);
  localparam bit WD_ENABLED = (TIMEOUT_CYCLES != 0);

  bus_state_e             state_q, state_d;
  logic [GRANT_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [WD_WIDTH-1:0]    watchdog_q, watchdog_d;

  logic                     bus_vaild_d, bus_we_d, req_error_d;
  logic [ADDRESS_WIDTH-1:0] bus_address_d;
  logic [DATA_WIDTH-1:0]    bus_data_write_d, req_data_read_d;
  logic [CHANNELS-1:0]      req_ready_d;
  logic [GRANT_WIDTH-1:0]   grant_d, winner;
  logic                     any_valid;

  logic [ADDRESS_WIDTH-1:0] req_address [CHANNELS];
  logic [DATA_WIDTH-1:0]    req_data    [CHANNELS];

  // Unpack the per-channel payload buses, channel 0 in the LSBs.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign req_address[c] = i_req_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign req_data[c]    = i_req_data_write[c*DATA_WIDTH +: DATA_WIDTH];
  end

  bus_arbiter_picker #(
    .CHANNELS (CHANNELS)
  ) u_picker (
    .req_valid  (i_req_vaild),
    .last_grant (last_grant_q),
    .mode       (ROUND_ROBIN ? ARB_ROUND_ROBIN : ARB_FIXED),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Next-state and next-output decode; registered outputs hold by default.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    watchdog_d       = watchdog_q;
    bus_vaild_d      = o_bus_vaild;
    bus_we_d         = o_bus_write_enable;
    bus_address_d    = o_bus_address;
    bus_data_write_d = o_bus_data_write;
    grant_d          = o_grant_id;
    req_data_read_d  = o_req_data_read;
    req_ready_d      = '0;
    req_error_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus_vaild_d = 1'b0;
        if (any_valid && !i_bus_busy) begin
          bus_vaild_d      = 1'b1;
          bus_we_d         = i_req_write_enable[winner];
          bus_address_d    = req_address[winner];
          bus_data_write_d = req_data[winner];
          grant_d          = winner;
          last_grant_d     = winner;
          watchdog_d       = '0;
          state_d          = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_bus_ready) begin
          bus_vaild_d             = 1'b0;
          req_ready_d[o_grant_id] = 1'b1;
          req_data_read_d         = i_bus_data_read;
          state_d                 = ST_DONE;
        end else if (WD_ENABLED && watchdog_q == WD_LIMIT) begin
          bus_vaild_d             = 1'b0;
          req_ready_d[o_grant_id] = 1'b1;
          req_error_d             = 1'b1;
          req_data_read_d         = '0;
          state_d                 = ST_DONE;
        end else if (WD_ENABLED) begin
          watchdog_d = watchdog_q + WD_ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (i_reset) begin
      state_q            <= ST_IDLE;
      last_grant_q       <= GRANT_WIDTH'(CHANNELS - 1);
      watchdog_q         <= '0;
      o_bus_vaild        <= 1'b0;
      o_bus_write_enable <= 1'b0;
      o_bus_address      <= '0;
      o_bus_data_write   <= '0;
      o_grant_id         <= '0;
      o_req_ready        <= '0;
      o_req_error        <= 1'b0;
      o_req_data_read    <= '0;
    end else begin
      state_q            <= state_d;
      last_grant_q       <= last_grant_d;
      watchdog_q         <= watchdog_d;
      o_bus_vaild        <= bus_vaild_d;
      o_bus_write_enable <= bus_we_d;
      o_bus_address      <= bus_address_d;
      o_bus_data_write   <= bus_data_write_d;
      o_grant_id         <= grant_d;
      o_req_ready        <= req_ready_d;
      o_req_error        <= req_error_d;
      o_req_data_read    <= req_data_read_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_unit.sv
// Directed self-checking bench: a round-robin unit with a short watchdog and
// a fixed-priority unit with the watchdog disabled share one stimulus.
module tb_bus_arbiter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we;
  logic [63:0] req_addr, req_wdata;
  logic        bus_ready, bus_busy;
  logic [31:0] bus_rdata;

  logic [1:0]  rr_ready, fp_ready;
  logic        rr_error, fp_error;
  logic [31:0] rr_rdata, fp_rdata;
  logic        rr_vaild, fp_vaild, rr_we, fp_we;
  logic [31:0] rr_addr, fp_addr, rr_wdata, fp_wdata;
  logic        rr_grant, fp_grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_unit #(
    .CHANNELS(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(4)
  ) dut_rr (
    .i_clock(clk), .i_reset(rst),
    .i_req_vaild(req_valid), .o_req_ready(rr_ready), .o_req_error(rr_error),
    .i_req_write_enable(req_we), .i_req_address(req_addr),
    .i_req_data_write(req_wdata), .o_req_data_read(rr_rdata),
    .o_bus_vaild(rr_vaild), .o_bus_write_enable(rr_we),
    .o_bus_address(rr_addr), .o_bus_data_write(rr_wdata),
    .i_bus_ready(bus_ready), .i_bus_busy(bus_busy),
    .i_bus_data_read(bus_rdata), .o_grant_id(rr_grant)
  );

  bus_arbiter_unit #(
    .CHANNELS(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(0)
  ) dut_fp (
    .i_clock(clk), .i_reset(rst),
    .i_req_vaild(req_valid), .o_req_ready(fp_ready), .o_req_error(fp_error),
    .i_req_write_enable(req_we), .i_req_address(req_addr),
    .i_req_data_write(req_wdata), .o_req_data_read(fp_rdata),
    .o_bus_vaild(fp_vaild), .o_bus_write_enable(fp_we),
    .o_bus_address(fp_addr), .o_bus_data_write(fp_wdata),
    .i_bus_ready(bus_ready), .i_bus_busy(bus_busy),
    .i_bus_data_read(bus_rdata), .o_grant_id(fp_grant)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Each tick lands mid-cycle: outputs are sampled, then next inputs are set.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_busy = 1'b0; bus_rdata = '0;
    tick(); tick();

    // Reset state
    check("rst_vaild", rr_vaild, 0);
    check("rst_ready", rr_ready, 0);
    check("rst_grant", rr_grant, 0);
    check("rst_rdata", rr_rdata, 0);

    // Single read on ch0, bus ready two cycles after the grant
    rst = 1'b0; req_valid = 2'b01; req_addr[31:0] = 32'h1000;   // cycle 0
    tick();                                                       // cycle 1
    check("rd_vaild_c1", rr_vaild, 1);
    check("rd_addr", rr_addr, 32'h1000);
    check("rd_we", rr_we, 0);
    check("rd_grant", rr_grant, 0);
    tick();                                                       // cycle 2
    check("rd_vaild_c2", rr_vaild, 1);
    check("rd_noready_c2", rr_ready, 0);
    tick();                                                       // cycle 3
    check("rd_vaild_c3", rr_vaild, 1);
    bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    tick();                                                       // cycle 4
    check("rd_ready", rr_ready, 2'b01);
    check("rd_data", rr_rdata, 32'hDEADBEEF);
    check("rd_error", rr_error, 0);
    check("rd_vaild_c4", rr_vaild, 0);
    bus_ready = 1'b0; req_valid = 2'b00;
    tick();                                                       // cycle 5
    check("rd_ready_pulse", rr_ready, 0);
    check("rd_data_hold", rr_rdata, 32'hDEADBEEF);

    // Both channels requesting, zero-wait bus: RR alternates, FP stays on 0
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 2'b11; bus_ready = 1'b1;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_grant_%0d", k), rr_grant, k % 2);
      check($sformatf("rr_addr_%0d", k), rr_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      check($sformatf("fp_grant_%0d", k), fp_grant, 0);
      tick();
      check($sformatf("rr_ready_%0d", k), rr_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("fp_ready_%0d", k), fp_ready, 2'b01);
      tick();
    end

    // Write on ch1; payload changes while the transfer is in WAIT
    req_valid = 2'b10; req_we = 2'b10; bus_ready = 1'b0;
    req_addr[63:32] = 32'h20; req_wdata[63:32] = 32'h55AA55AA;
    tick();
    req_we = 2'b00; req_addr[63:32] = 32'h9999; req_wdata[63:32] = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wr_we_%0d", k), rr_we, 1);
      check($sformatf("wr_addr_%0d", k), rr_addr, 32'h20);
      check($sformatf("wr_data_%0d", k), rr_wdata, 32'h55AA55AA);
      check($sformatf("wr_grant_%0d", k), rr_grant, 1);
      if (k == 2) bus_ready = 1'b1;
      tick();
    end
    check("wr_ready", rr_ready, 2'b10);
    check("wr_error", rr_error, 0);
    req_valid = 2'b00; bus_ready = 1'b0;
    tick();

    // Busy bus blocks the grant until it drops; busy is ignored in WAIT
    bus_busy = 1'b1; req_valid = 2'b01; req_addr[31:0] = 32'h44;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("busy_novaild_%0d", k), rr_vaild, 0);
    end
    bus_busy = 1'b0;
    tick();
    check("busy_grant_vaild", rr_vaild, 1);
    check("busy_grant_addr", rr_addr, 32'h44);
    bus_busy = 1'b1; bus_ready = 1'b1;
    tick();
    check("busy_wait_ready", rr_ready, 2'b01);
    req_valid = 2'b00; bus_busy = 1'b0; bus_ready = 1'b0;
    tick();

    // Watchdog abort on RR (4 cycles); FP has no watchdog and keeps waiting
    req_valid = 2'b01; req_addr[31:0] = 32'h80; bus_rdata = 32'hCAFEF00D;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("to_vaild_c%0d", k), rr_vaild, 1);
      check($sformatf("to_noready_c%0d", k), rr_ready, 0);
    end
    tick();                                                       // cycle 5
    check("to_ready", rr_ready, 2'b01);
    check("to_error", rr_error, 1);
    check("to_data", rr_rdata, 0);
    check("to_vaild_drop", rr_vaild, 0);
    check("fp_no_timeout", fp_vaild, 1);
    req_valid = 2'b00;
    tick();                                                       // cycle 6
    check("to_ready_clear", rr_ready, 0);
    check("to_error_clear", rr_error, 0);
    req_valid = 2'b01; req_addr[31:0] = 32'h84; bus_ready = 1'b1;
    bus_rdata = 32'h0BADF00D;
    tick();                                                       // cycle 7
    check("post_to_vaild", rr_vaild, 1);
    check("post_to_addr", rr_addr, 32'h84);
    check("fp_late_ready", fp_ready, 2'b01);
    check("fp_late_data", fp_rdata, 32'h0BADF00D);
    tick();                                                       // cycle 8
    check("post_to_ready", rr_ready, 2'b01);
    check("post_to_error", rr_error, 0);
    check("post_to_data", rr_rdata, 32'h0BADF00D);
    req_valid = 2'b00; bus_ready = 1'b0;
    tick();

    // Reset during WAIT clears everything; first grant afterwards is ch0
    req_valid = 2'b11; req_addr = {32'h0000_0300, 32'h0000_0310};
    tick();
    check("prerst_rr_grant", rr_grant, 1);
    check("prerst_fp_grant", fp_grant, 0);
    check("prerst_vaild", rr_vaild, 1);
    rst = 1'b1;
    tick();
    check("wrst_vaild", rr_vaild, 0);
    check("wrst_addr", rr_addr, 0);
    check("wrst_grant", rr_grant, 0);
    check("wrst_rdata", rr_rdata, 0);
    check("wrst_ready", rr_ready, 0);
    check("wrst_fp_vaild", fp_vaild, 0);
    check("wrst_fp_rdata", fp_rdata, 0);
    rst = 1'b0;
    tick();
    check("postrst_vaild", rr_vaild, 1);
    check("postrst_grant", rr_grant, 0);
    check("postrst_addr", rr_addr, 32'h310);
    check("postrst_ready", rr_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
